// File: rtl/pipelined_csa_sub16_pkg.sv
// Shared widths and stage-1 payload for the two-stage carry-select subtractor.
package pipelined_csa_sub16_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NUM_NIB = 4;
    localparam int unsigned LO_W    = 2 * NIB_W;

    // Stage-1 register contents: resolved low byte plus both speculative
    // versions of nibbles 2 and 3 (index 0 = no borrow in, 1 = borrow in).
    typedef struct packed {
        logic [LO_W-1:0]  lo;
        logic             b8;
        logic [NIB_W-1:0] n2_0;
        logic [NIB_W-1:0] n2_1;
        logic [NIB_W-1:0] n3_0;
        logic [NIB_W-1:0] n3_1;
        logic             bo2_0;
        logic             bo2_1;
        logic             bo3_0;
        logic             bo3_1;
    } s1_t;

endpackage

// File: rtl/nibble_sub4.sv
// 4-bit ripple subtractor.
//   a, b : nibble operands (a - b)
//   bin  : borrow in
//   diff : (a - b - bin) mod 16
//   bout : borrow out (a < b + bin)
module nibble_sub4
    import pipelined_csa_sub16_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] diff,
    output logic             bout
);

    logic [NIB_W:0] br;

    // Full-subtractor chain, bit 0 upward.
    always_comb begin
        br    = '0;
        diff  = '0;
        br[0] = bin;
        for (int i = 0; i < int'(NIB_W); i++) begin
            diff[i]  = a[i] ^ b[i] ^ br[i];
            br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bout = br[NIB_W];
    end

endmodule

// File: rtl/pipelined_csa_sub16.sv
// Two-stage pipelined 16-bit carry-select subtractor with valid/ready
// handshakes on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (in_ready is combinational)
//   a, b, bin           : minuend, subtrahend, borrow-in
//   out_valid/out_ready : result handshake
//   diff, bout          : (a - b - bin) mod 2^16 and borrow-out
module pipelined_csa_sub16
    import pipelined_csa_sub16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              bout
);

    logic             s1_valid;
    s1_t              s1_q;
    s1_t              s1_d;
    logic             s2_adv;
    logic             s1_adv;

    logic [NIB_W-1:0] lo_d [2];
    logic             lo_bo [2];
    logic [NIB_W-1:0] up_d [2][2];
    logic             up_bo [2][2];

    // Low byte: nibble 1 rides on nibble 0's borrow.
    nibble_sub4 u_nib0 (
        .a    (a[NIB_W-1:0]),
        .b    (b[NIB_W-1:0]),
        .bin  (bin),
        .diff (lo_d[0]),
        .bout (lo_bo[0])
    );

    nibble_sub4 u_nib1 (
        .a    (a[2*NIB_W-1:NIB_W]),
        .b    (b[2*NIB_W-1:NIB_W]),
        .bin  (lo_bo[0]),
        .diff (lo_d[1]),
        .bout (lo_bo[1])
    );

    // Upper nibbles computed for both possible incoming borrows.
    for (genvar n = 0; n < 2; n++) begin : g_up
        for (genvar c = 0; c < 2; c++) begin : g_spec
            nibble_sub4 u_nib (
                .a    (a[(n+2)*NIB_W +: NIB_W]),
                .b    (b[(n+2)*NIB_W +: NIB_W]),
                .bin  (1'(c)),
                .diff (up_d[n][c]),
                .bout (up_bo[n][c])
            );
        end
    end

    // Pack stage-1 payload.
    always_comb begin
        s1_d       = '0;
        s1_d.lo    = {lo_d[1], lo_d[0]};
        s1_d.b8    = lo_bo[1];
        s1_d.n2_0  = up_d[0][0];
        s1_d.n2_1  = up_d[0][1];
        s1_d.n3_0  = up_d[1][0];
        s1_d.n3_1  = up_d[1][1];
        s1_d.bo2_0 = up_bo[0][0];
        s1_d.bo2_1 = up_bo[0][1];
        s1_d.bo3_0 = up_bo[1][0];
        s1_d.bo3_1 = up_bo[1][1];
    end

    // Stage 2 loads when its slot is free or being drained; stage 1 likewise.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage-1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage-2 select: nibble 2 by b8, nibble 3 by the chosen nibble-2 borrow.
    logic [NIB_W-1:0] sel_n2;
    logic             sel_bo2;
    logic [NIB_W-1:0] sel_n3;
    logic             sel_bo3;

    assign sel_n2  = s1_q.b8 ? s1_q.n2_1  : s1_q.n2_0;
    assign sel_bo2 = s1_q.b8 ? s1_q.bo2_1 : s1_q.bo2_0;
    assign sel_n3  = sel_bo2 ? s1_q.n3_1  : s1_q.n3_0;
    assign sel_bo3 = sel_bo2 ? s1_q.bo3_1 : s1_q.bo3_0;

    // Stage-2 / output register; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= {sel_n3, sel_n2, s1_q.lo};
                bout <= sel_bo3;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_csa_sub16.sv
// Scoreboard bench for pipelined_csa_sub16: directed vectors with
// hand-computed results, backpressure, reset flush, and a random stream.
module tb_pipelined_csa_sub16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;

    int checks   = 0;
    int failures = 0;

    logic [16:0] sb [$];

    pipelined_csa_sub16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand set from posedge+1; returns at posedge+1 after
    // acceptance. waits = edges that passed without acceptance.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tbin, input logic [16:0] texp,
                        output int waits);
        logic acc;
        waits    = 0;
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sb.push_back(texp);
                break;
            end
            waits++;
            if (waits > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: in_ready stuck low, required acceptance");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pop and compare on each output transfer; check hold stability.
    logic [16:0] exp_v;
    logic [16:0] hold_val;
    logic        hold_v = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!out_valid || {bout, diff} !== hold_val) begin
                    failures++;
                    $display("FAIL hold: got v=%0b 0x%05h, required v=1 0x%05h",
                             out_valid, {bout, diff}, hold_val);
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_val = {bout, diff};
            if (out_valid && sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious: got out_valid=1 0x%05h, required no result", {bout, diff});
            end else if (out_valid && out_ready) begin
                exp_v = sb.pop_front();
                checks++;
                if ({bout, diff} !== exp_v) begin
                    failures++;
                    $display("FAIL result: got {bout,diff}=0x%05h, required 0x%05h",
                             {bout, diff}, exp_v);
                end
            end
        end
    end

    localparam int NDIR = 11;
    logic [15:0] da [NDIR] = '{16'h0100, 16'h1234, 16'hF000, 16'h0005, 16'hFFFF, 16'h8000,
                               16'h0000, 16'hABCD, 16'h1000, 16'h00FF, 16'h0001};
    logic [15:0] db [NDIR] = '{16'h0001, 16'h1234, 16'h0FFF, 16'h0003, 16'h0000, 16'h8001,
                               16'h0000, 16'h1234, 16'h0001, 16'h0100, 16'h0001};
    logic        dbin [NDIR] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [16:0] dexp [NDIR] = '{17'h000FF, 17'h1FFFF, 17'h0E000, 17'h00002, 17'h0FFFE, 17'h1FFFF,
                                 17'h00000, 17'h09999, 17'h00FFE, 17'h1FFFF, 17'h1FFFF};

    int w;
    int w3;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'h0000);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First transfer on the first edge after release, 2-cycle latency.
        send(16'h0000, 16'h0001, 1'b0, 17'h1FFFF, w);
        chk("first_accept_waits", 32'(w), 32'd0);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors at full throughput.
        for (int i = 0; i < NDIR; i++) begin
            send(da[i], db[i], dbin[i], dexp[i], w);
            chk("throughput_waits", 32'(w), 32'd0);
        end
        drain();

        // Bubble: nothing offered, nothing emerges.
        repeat (3) begin
            @(negedge clk);
            chk("bubble_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Backpressure: two accepted, third stalls, results in order.
        out_ready = 1'b0;
        send(16'h0010, 16'h0001, 1'b0, 17'h0000F, w);
        chk("bp_first_waits", 32'(w), 32'd0);
        send(16'h2000, 16'h1000, 1'b1, 17'h00FFF, w);
        chk("bp_second_waits", 32'(w), 32'd0);
        fork
            send(16'h0003, 16'h0005, 1'b0, 17'h1FFFE, w3);
        join_none
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_diff_held", 32'({bout, diff}), 32'h0000F);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        chk("bp_third_accepted", 32'(w3 > 0 && w3 < 200), 32'd1);
        drain();

        // Reset with two results in flight discards them.
        send(16'h5555, 16'h1111, 1'b0, 17'h04444, w);
        send(16'h0000, 16'h0002, 1'b0, 17'h1FFFE, w);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(diff), 32'h0000);
        chk("midrst_bout", 32'(bout), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h7777, 16'h1111, 1'b0, 17'h06666, w);
        chk("post_rst_accept", 32'(w), 32'd0);
        @(negedge clk);
        chk("post_rst_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_lat2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Random stream against the 17-bit reference.
        begin
            int          sent = 0;
            logic        acc;
            logic [16:0] pend = '0;
            in_valid = 1'b0;
            while (sent < 10000) begin
                out_ready = ($urandom_range(9) < 7);
                if (!in_valid && $urandom_range(3) != 0) begin
                    a        = 16'($urandom);
                    b        = 16'($urandom);
                    bin      = 1'($urandom_range(1));
                    pend     = {1'b0, a} - {1'b0, b} - 17'(bin);
                    in_valid = 1'b1;
                end
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (acc) begin
                    sb.push_back(pend);
                    in_valid = 1'b0;
                    sent++;
                end
            end
            out_ready = 1'b1;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_csa_sub16.md
PIPELINED_CSA_SUB16 -- requirements
Module: pipelined_csa_sub16

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 16 bits and split into four 4-bit nibbles.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state rising-edge triggered.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand set a/b/bin valid this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  16  minuend.
REQ-008 b  input  16  subtrahend.
REQ-009 bin  input  1  borrow-in.
REQ-010 out_valid  output  1  diff/bout valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 diff  output  16  (a - b - bin) mod 2^16.
REQ-013 bout  output  1  borrow-out: 1 iff a < b + bin, treating a and b as unsigned.

Function
REQ-014 A transfer SHALL occur on an input when in_valid && in_ready, and on an output when out_valid && out_ready, both sampled at the rising clk edge.
REQ-015 Stage 1 SHALL compute diff[7:0] by ripple subtraction over nibbles 0-1 with borrow-in bin.
REQ-016 Stage 1 SHALL compute nibbles 2-3 speculatively for both borrow=0 and borrow=1, giving four nibble results plus their borrow-outs.
REQ-017 Stage 1 SHALL register diff[7:0], borrow b8, and all speculative upper results.
REQ-018 Stage 2 SHALL select the nibble-2 result using b8.
REQ-019 Stage 2 SHALL select the nibble-3 result using the selected nibble-2 borrow.
REQ-020 Stage 2 SHALL register diff[15:8] and bout.
REQ-021 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-022 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-023 Stage 2 SHALL advance (load) when !out_valid || out_ready.
REQ-024 Stage 1 SHALL advance when !s1_valid || stage 2 advances.
REQ-025 in_ready SHALL equal the stage-1 advance condition; in_ready MAY depend combinationally on out_ready.
REQ-026 While out_valid && !out_ready, diff and bout SHALL hold stable.
REQ-027 With two results held, in_ready SHALL be 0.
REQ-028 Simultaneous output transfer and input transfer in the same cycle SHALL lose no data and SHALL not duplicate any data.
REQ-029 Results SHALL leave in strict input order.
REQ-030 Wrap-around: underflow SHALL wrap mod 2^16 and set bout=1.
REQ-031 a == b with bin=1 SHALL give diff=0xFFFF, bout=1.
REQ-032 in_valid=0 SHALL create a bubble: the stage valid clears and no spurious out_valid appears.

Reset
REQ-033 rst_n low SHALL immediately clear all stage valids, so out_valid=0.
REQ-034 rst_n low SHALL set diff=0x0000 and bout=0.
REQ-035 During reset, in_ready SHALL be 1, given the pipeline is empty.
REQ-036 Reset asserted mid-operation SHALL discard in-flight operands; no result for them SHALL appear after release.
REQ-037 The first transfer after reset SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-038 A shared package SHALL hold DATA_W=16, NIB_W=4, NUM_NIB=4.
REQ-039 One sub-module nibble_sub4 SHALL be used (4-bit ripple subtractor: a, b, bin -> diff, bout), instantiated 6 times: nibbles 0-1 once, nibbles 2-3 twice each.
REQ-040 Only stage registers and their valid flags SHALL be sequential; the selects SHALL be plain 2:1 muxes.

Verification
REQ-041 a=0x0000, b=0x0001, bin=0 -> two cycles later diff=0xFFFF, bout=1.
REQ-042 a=0x0100, b=0x0001, bin=0 -> diff=0x00FF, bout=0 (borrow crosses stage boundary).
REQ-043 a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, bout=1; a=0xF000, b=0x0FFF, bin=1 -> diff=0xE000, bout=0.
REQ-044 Hold out_ready=0 and offer 3 back-to-back inputs -> first two accepted, in_ready=0 on the third, diff stable; raise out_ready -> results emerge in order, third then accepted.
REQ-045 Drop rst_n while two results are in flight -> out_valid=0 immediately; after release, no stale results appear and the next input yields the correct result 2 cycles later.
REQ-046 Random streams (10k vectors) with random in_valid/out_ready SHALL match a reference model of {bout,diff} = a - b - bin on 17 bits, with in-order delivery and no loss or duplication.
